// File: rtl/sh_wdt.sv
// sh_wdt: SH-style watchdog / interval timer on the on-chip IBUS (FFFFFE80..FFFFFE83).
// Define SH_WDT_RSTCSR_EN to implement RSTCSR (WOVF, RSTE) and the WRES_REQ internal reset request.
module sh_wdt #(
  parameter int OVF_PULSE = 128,
  parameter int RES_PULSE = 512
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  output logic        WDT_IRQ,
  output logic        WDTOVF_N,
  output logic        WRES_REQ
);

`ifdef SH_WDT_RSTCSR_EN
  localparam bit RSTCSR_EN = 1'b1;
`else
  localparam bit RSTCSR_EN = 1'b0;
`endif

  localparam int OVF_CW = $clog2(OVF_PULSE + 1);
  localparam int RES_CW = $clog2(RES_PULSE + 1);

  typedef enum logic {
    IDLE,
    OVFP
  } pulse_state_t;

  logic              soft_rst;
  logic              wr_en;
  logic              rd_en;
  logic              wr_csr;
  logic              wr_rst;
  logic [7:0]        csr_key;
  logic [7:0]        csr_data;
  logic [7:0]        rst_key;
  logic [7:0]        rst_data;
  logic              wtcnt_wr;
  logic              wtcsr_wr;
  logic              wovf_clr;
  logic              rste_wr;

  logic              ovf;
  logic              wt_it;
  logic              tme;
  logic [2:0]        cks;
  logic [7:0]        wtcnt;
  logic [12:0]       presc;
  logic              clr_arm;
  logic              wovf;
  logic              rste;

  logic              tick;
  logic              wrap;
  logic              ovf_set;
  logic              ovf_clr;
  logic              wdt_ovf;
  logic [7:0]        wtcsr_rd;
  logic [7:0]        rstcsr_rd;

  pulse_state_t      ovf_state;
  logic [OVF_CW-1:0] ovf_cnt;
  logic [RES_CW-1:0] res_cnt;

  logic              unused_bits;

  // RES_N acts as a reset only when sampled on the rising-phase enable.
  assign soft_rst  = RST | (CE_R & ~RES_N);

  assign IBUS_BUSY = 1'b0;
  assign IBUS_ACT  = (IBUS_A >= 32'hFFFF_FE80) && (IBUS_A <= 32'hFFFF_FE83);

  assign wr_en     = IBUS_REQ & IBUS_WE & IBUS_ACT;
  assign rd_en     = IBUS_REQ & ~IBUS_WE & IBUS_ACT;

  assign csr_key   = IBUS_DI[31:24];
  assign csr_data  = IBUS_DI[23:16];
  assign rst_key   = IBUS_DI[15:8];
  assign rst_data  = IBUS_DI[7:0];

  assign wr_csr    = wr_en & ~IBUS_A[1] & (IBUS_BA[3:2] == 2'b11);
  assign wr_rst    = wr_en &  IBUS_A[1] & (IBUS_BA[1:0] == 2'b11) & RSTCSR_EN;

  assign wtcnt_wr  = wr_csr & (csr_key == 8'h5A);
  assign wtcsr_wr  = wr_csr & (csr_key == 8'hA5);
  assign wovf_clr  = wr_rst & (rst_key == 8'hA5) & (rst_data == 8'h00);
  assign rste_wr   = wr_rst & (rst_key == 8'h5A);

  // WTCSR[4:3] are constant-one read bits, so their write data has no destination.
  assign unused_bits = &{1'b0, csr_data[4:3]};

  always_comb begin
    tick = 1'b0;
    if (tme) begin
      case (cks)
        3'd0: tick = presc[0];
        3'd1: tick = &presc[5:0];
        3'd2: tick = &presc[6:0];
        3'd3: tick = &presc[7:0];
        3'd4: tick = &presc[8:0];
        3'd5: tick = &presc[9:0];
        3'd6: tick = &presc[11:0];
        3'd7: tick = &presc[12:0];
      endcase
    end
  end

  // A CPU write to WTCNT in the same CE_R as a tick suppresses the overflow.
  assign wrap      = CE_R & tick & (wtcnt == 8'hFF) & ~wtcnt_wr;
  assign ovf_set   = wrap & ~wt_it;
  assign wdt_ovf   = wrap &  wt_it;
  assign ovf_clr   = CE_R & wtcsr_wr & ~csr_data[7] & clr_arm;

  assign wtcsr_rd  = {ovf, wt_it, tme, 2'b11, cks};
  assign rstcsr_rd = {wovf, rste, 1'b0, 5'h1F};

  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      ovf   <= 1'b0;
      wt_it <= 1'b0;
      tme   <= 1'b0;
      cks   <= 3'd0;
      wtcnt <= 8'h00;
      presc <= 13'd0;
    end else if (CE_R) begin
      presc <= tme ? presc + 13'd1 : 13'd0;
      if (wtcnt_wr) begin
        wtcnt <= csr_data;
      end else if (tick) begin
        wtcnt <= wtcnt + 8'd1;
      end
      if (wtcsr_wr) begin
        wt_it <= csr_data[6];
        tme   <= csr_data[5];
        cks   <= csr_data[2:0];
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // OVF may only be cleared after software has observed it set.
  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      clr_arm <= 1'b0;
    end else if (CE_R && (ovf_set || ovf_clr)) begin
      clr_arm <= 1'b0;
    end else if (CE_F && rd_en && !IBUS_A[1] && ovf) begin
      clr_arm <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      wovf <= 1'b0;
      rste <= 1'b0;
    end else if (CE_R) begin
      if (wdt_ovf && RSTCSR_EN) begin
        wovf <= 1'b1;
      end else if (wovf_clr) begin
        wovf <= 1'b0;
      end
      if (rste_wr) begin
        rste <= rst_data[6];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      IBUS_DO <= 32'h0000_0000;
    end else if (CE_F && rd_en) begin
      IBUS_DO <= IBUS_A[1] ? {24'hFF_FFFF, rstcsr_rd} : {wtcsr_rd, wtcnt, 16'hFFFF};
    end
  end

  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      WDT_IRQ <= 1'b0;
    end else if (CE_R) begin
      WDT_IRQ <= ovf & ~wt_it & tme;
    end
  end

  // A fresh watchdog overflow restarts the WDTOVF_N pulse from the beginning.
  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      ovf_state <= IDLE;
      ovf_cnt   <= '0;
      WDTOVF_N  <= 1'b1;
    end else if (CE_R) begin
      if (wdt_ovf) begin
        ovf_state <= OVFP;
        ovf_cnt   <= '0;
        WDTOVF_N  <= 1'b0;
      end else begin
        case (ovf_state)
          IDLE: begin
            WDTOVF_N <= 1'b1;
          end
          OVFP: begin
            if (ovf_cnt == OVF_CW'(OVF_PULSE - 1)) begin
              ovf_state <= IDLE;
              WDTOVF_N  <= 1'b1;
            end else begin
              ovf_cnt <= ovf_cnt + OVF_CW'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      WRES_REQ <= 1'b0;
      res_cnt  <= '0;
    end else if (CE_R) begin
      if (wdt_ovf && rste) begin
        WRES_REQ <= 1'b1;
        res_cnt  <= '0;
      end else if (WRES_REQ) begin
        if (res_cnt == RES_CW'(RES_PULSE - 1)) begin
          WRES_REQ <= 1'b0;
        end else begin
          res_cnt <= res_cnt + RES_CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sh_wdt.sv
// tb_sh_wdt: directed, table-driven bench for the sh_wdt watchdog timer.
// Expected RSTCSR/WRES_REQ values follow SH_WDT_RSTCSR_EN.
module tb_sh_wdt;

`ifdef SH_WDT_RSTCSR_EN
  localparam logic [31:0] RSTCSR_WOVF_RD = 32'hFFFF_FFDF;
  localparam logic [31:0] RSTCSR_CLR_RD  = 32'hFFFF_FF5F;
  localparam int          WRES_CYCLES    = 512;
`else
  localparam logic [31:0] RSTCSR_WOVF_RD = 32'hFFFF_FF1F;
  localparam logic [31:0] RSTCSR_CLR_RD  = 32'hFFFF_FF1F;
  localparam int          WRES_CYCLES    = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_r = 1'b0;
  logic        ce_f = 1'b0;
  logic        res_n = 1'b1;
  logic [31:0] ibus_a = '0;
  logic [31:0] ibus_di = '0;
  logic [31:0] ibus_do;
  logic [3:0]  ibus_ba = '0;
  logic        ibus_we = 1'b0;
  logic        ibus_req = 1'b0;
  logic        ibus_busy;
  logic        ibus_act;
  logic        wdt_irq;
  logic        wdtovf_n;
  logic        wres_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] di;
    logic [3:0]  ba;
    logic        we;
    logic        req;
    logic [31:0] exp_do;
    logic        exp_irq;
    logic        exp_act;
  } vec_t;

  vec_t vecs[13];

  sh_wdt dut (
    .CLK      (clk),
    .RST      (rst),
    .CE_R     (ce_r),
    .CE_F     (ce_f),
    .RES_N    (res_n),
    .IBUS_A   (ibus_a),
    .IBUS_DI  (ibus_di),
    .IBUS_DO  (ibus_do),
    .IBUS_BA  (ibus_ba),
    .IBUS_WE  (ibus_we),
    .IBUS_REQ (ibus_req),
    .IBUS_BUSY(ibus_busy),
    .IBUS_ACT (ibus_act),
    .WDT_IRQ  (wdt_irq),
    .WDTOVF_N (wdtovf_n),
    .WRES_REQ (wres_req)
  );

  always #5 clk = ~clk;

  // One bus step: a CE_R clock followed by a CE_F clock, bus held across both.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] di,
                               input logic [3:0] ba, input logic we, input logic req);
    ibus_a   = a;
    ibus_di  = di;
    ibus_ba  = ba;
    ibus_we  = we;
    ibus_req = req;
    ce_r = 1'b1;
    ce_f = 1'b0;
    @(posedge clk);
    #1;
    ce_r = 1'b0;
    ce_f = 1'b1;
    @(posedge clk);
    #1;
    ce_f = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    res_n = 1'b1;
    ce_r = 1'b0;
    ce_f = 1'b0;
    ibus_req = 1'b0;
    ibus_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic writeCsr(input logic [15:0] val, input logic [3:0] ba);
    applyStimulus(32'hFFFF_FE80, {val, 16'h0000}, ba, 1'b1, 1'b1);
  endtask

  task automatic writeRst(input logic [15:0] val, input logic [3:0] ba);
    applyStimulus(32'hFFFF_FE82, {16'h0000, val}, ba, 1'b1, 1'b1);
  endtask

  task automatic readReg(input logic [31:0] a);
    applyStimulus(a, 32'h0, 4'b1111, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lo_count;
    int wres_count;

    vecs[0]  = '{32'hFFFF_FE80, 32'hA520_0000, 4'b1100, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[1]  = '{32'hFFFF_FE80, 32'h5AFE_0000, 4'b1100, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{32'hFFFF_FE80, 32'hA520_0000, 4'b1100, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7]  = '{32'hFFFF_FE80, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'hB801_FFFF, 1'b1, 1'b1};
    vecs[8]  = '{32'hFFFF_FE80, 32'hA520_0000, 4'b1100, 1'b1, 1'b1, 32'hB801_FFFF, 1'b1, 1'b1};
    vecs[9]  = '{32'hFFFF_FE80, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'h3802_FFFF, 1'b0, 1'b1};
    vecs[10] = '{32'hFFFF_FE83, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'hFFFF_FF1F, 1'b0, 1'b1};
    vecs[11] = '{32'hFFFF_FE84, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'hFFFF_FF1F, 1'b0, 1'b0};
    vecs[12] = '{32'hFFFF_FE7F, 32'h0000_0000, 4'b1111, 1'b0, 1'b1, 32'hFFFF_FF1F, 1'b0, 1'b0};

    $display("[TB] reset and idle readback");
    doReset();
    checkOutput("reset do", ibus_do, 32'h0);
    checkOutput("reset irq", {31'b0, wdt_irq}, 32'h0);
    checkOutput("reset wdtovf_n", {31'b0, wdtovf_n}, 32'h1);
    checkOutput("reset wres_req", {31'b0, wres_req}, 32'h0);
    checkOutput("busy", {31'b0, ibus_busy}, 32'h0);
    readReg(32'hFFFF_FE80);
    checkOutput("reset read fe80", ibus_do, 32'h1800_FFFF);
    readReg(32'hFFFF_FE82);
    checkOutput("reset read fe82", ibus_do, 32'hFFFF_FF1F);

    $display("[TB] interval overflow vectors");
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].a, vecs[i].di, vecs[i].ba, vecs[i].we, vecs[i].req);
      checkOutput($sformatf("vec%0d do", i), ibus_do, vecs[i].exp_do);
      checkOutput($sformatf("vec%0d irq", i), {31'b0, wdt_irq}, {31'b0, vecs[i].exp_irq});
      checkOutput($sformatf("vec%0d act", i), {31'b0, ibus_act}, {31'b0, vecs[i].exp_act});
      checkOutput($sformatf("vec%0d wdtovf_n", i), {31'b0, wdtovf_n}, 32'h1);
    end

    $display("[TB] bad key and byte writes");
    doReset();
    writeCsr(16'h3312, 4'b1100);
    writeCsr(16'h5A12, 4'b1000);
    writeCsr(16'hA560, 4'b0100);
    writeRst(16'h5A40, 4'b0001);
    writeRst(16'h3340, 4'b0011);
    readReg(32'hFFFF_FE80);
    checkOutput("badkey fe80", ibus_do, 32'h1800_FFFF);
    readReg(32'hFFFF_FE82);
    checkOutput("badkey fe82", ibus_do, 32'hFFFF_FF1F);
    writeCsr(16'h5A12, 4'b1100);
    readReg(32'hFFFF_FE80);
    checkOutput("goodkey wtcnt", ibus_do, 32'h1812_FFFF);

    $display("[TB] write versus tick collision");
    doReset();
    writeCsr(16'hA520, 4'b1100);
    writeCsr(16'h5AFF, 4'b1100);
    writeCsr(16'h5A10, 4'b1100);
    readReg(32'hFFFF_FE80);
    checkOutput("collision read", ibus_do, 32'h3810_FFFF);
    idleSteps(2);
    checkOutput("collision irq", {31'b0, wdt_irq}, 32'h0);

    $display("[TB] watchdog overflow pulses");
    doReset();
    writeRst(16'h5A40, 4'b0011);
    writeCsr(16'h5AFF, 4'b1100);
    writeCsr(16'hA560, 4'b1100);
    lo_count = 0;
    wres_count = 0;
    for (int j = 0; j < 600; j++) begin
      if (j == 2) writeCsr(16'hA500, 4'b1100);
      else idleSteps(1);
      if (j == 0) checkOutput("wdtovf_n before wrap", {31'b0, wdtovf_n}, 32'h1);
      if (j == 1) checkOutput("wdtovf_n on wrap", {31'b0, wdtovf_n}, 32'h0);
      if (!wdtovf_n) lo_count++;
      if (wres_req) wres_count++;
    end
    checkOutput("wdtovf_n low cycles", lo_count, 32'd128);
    checkOutput("wres_req high cycles", wres_count, WRES_CYCLES);
    checkOutput("wdtovf_n after pulse", {31'b0, wdtovf_n}, 32'h1);
    readReg(32'hFFFF_FE82);
    checkOutput("rstcsr wovf", ibus_do, RSTCSR_WOVF_RD);
    writeRst(16'hA500, 4'b0011);
    readReg(32'hFFFF_FE82);
    checkOutput("rstcsr cleared", ibus_do, RSTCSR_CLR_RD);
    readReg(32'hFFFF_FE80);
    checkOutput("wtcsr after mode change", ibus_do, 32'h1800_FFFF);

    $display("[TB] reset during pulse");
    doReset();
    writeCsr(16'h5AFF, 4'b1100);
    writeCsr(16'hA560, 4'b1100);
    idleSteps(2);
    checkOutput("pulse active before rst", {31'b0, wdtovf_n}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst aborts wdtovf_n", {31'b0, wdtovf_n}, 32'h1);
    checkOutput("rst aborts wres_req", {31'b0, wres_req}, 32'h0);

    writeCsr(16'h5AFF, 4'b1100);
    writeCsr(16'hA560, 4'b1100);
    idleSteps(2);
    checkOutput("pulse active before res_n", {31'b0, wdtovf_n}, 32'h0);
    res_n = 1'b0;
    idleSteps(1);
    res_n = 1'b1;
    checkOutput("res_n aborts wdtovf_n", {31'b0, wdtovf_n}, 32'h1);
    readReg(32'hFFFF_FE80);
    checkOutput("res_n clears regs", ibus_do, 32'h1800_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
